// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the timer/counter family: state encoding and width limits.
// Imported by the countdown timer and available to sibling counter blocks.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    CT_IDLE = 2'd0,
    CT_RUN  = 2'd1,
    CT_DONE = 2'd2
  } ct_state_e;

  localparam int CT_WIDTH_MIN = 2;
  localparam int CT_WIDTH_MAX = 32;

  function automatic bit ct_width_ok(input int w);
    return (w >= CT_WIDTH_MIN) && (w <= CT_WIDTH_MAX);
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between a countdown timer and the logic that sequences it.
// The master issues start/abort/pause and reads back count and status.
interface countdown_timer_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             abort;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc_pulse;
  logic             done;

  modport master (
    output load_val, start, pause, abort, auto_reload,
    input  count, busy, tc_pulse, done
  );

  modport slave (
    input  load_val, start, pause, abort, auto_reload,
    output count, busy, tc_pulse, done
  );

endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse, optional auto-reload and pause.
// All outputs are registered alongside the state.
//
// state   | meaning
// --------+-----------------------------------------------------------
// CT_IDLE | stopped, count=0, waiting for start
// CT_RUN  | counting down toward 1; terminal count fires from count==1
// CT_DONE | terminal count reached without reload; holds until start/abort
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  countdown_timer_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  ct_state_e        state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             busy_q;
  logic             done_q;
  logic             tc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CT_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      // abort keeps reload_q so a later start-less inspection still sees the last period
      if (bus.abort) begin
        state   <= CT_IDLE;
        count_q <= '0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state)
          CT_IDLE, CT_DONE: begin
            if (bus.start) begin
              reload_q <= bus.load_val;
              if (bus.load_val != '0) begin
                state   <= CT_RUN;
                count_q <= bus.load_val;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
              end else begin
                state   <= CT_DONE;
                count_q <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                tc_q    <= 1'b1;
              end
            end
          end
          CT_RUN: begin
            if (!bus.pause) begin
              if (count_q > ONE) begin
                count_q <= count_q - ONE;
              end else begin
                // terminal at count==1 so a reload period is exactly reload_q cycles
                tc_q <= 1'b1;
                if (bus.auto_reload) begin
                  count_q <= reload_q;
                end else begin
                  state   <= CT_DONE;
                  count_q <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end
            end
          end
          default: begin
            state   <= CT_IDLE;
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.count    = count_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tc_pulse = tc_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized bench for countdown_timer, checked every cycle against
// a rule-level reference model plus explicit constant checks at key points.
module tb_countdown_timer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // reference model: remaining count, period, and mode flags
  int m_cnt  = 0;
  int m_rel  = 0;
  bit m_run  = 0;
  bit m_done = 0;
  bit m_tc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_step();
    m_tc = 0;
    if (rst) begin
      m_cnt = 0; m_rel = 0; m_run = 0; m_done = 0;
    end else if (bus.abort) begin
      m_cnt = 0; m_run = 0; m_done = 0;
    end else if (!m_run) begin
      if (bus.start) begin
        m_rel = int'(bus.load_val);
        m_cnt = m_rel;
        m_run = (m_rel != 0);
        m_done = (m_rel == 0);
        m_tc = (m_rel == 0);
      end
    end else if (!bus.pause) begin
      if (m_cnt == 1) begin
        m_tc = 1;
        if (bus.auto_reload) m_cnt = m_rel;
        else begin m_cnt = 0; m_run = 0; m_done = 1; end
      end else begin
        m_cnt = m_cnt - 1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("count", 32'(bus.count), m_cnt);
    chk("busy", 32'(bus.busy), 32'(m_run));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("tc_pulse", 32'(bus.tc_pulse), 32'(m_tc));
  endtask

  task automatic do_start(input int v);
    bus.load_val = W'(v);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.load_val = '0; bus.start = 1'b0; bus.pause = 1'b0;
    bus.abort = 1'b0; bus.auto_reload = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 2; i++) begin
      rst = 1'b1;
      bus.load_val = W'($urandom); bus.start = 1'($urandom);
      bus.pause = 1'($urandom); bus.abort = 1'($urandom);
      bus.auto_reload = 1'($urandom);
      cyc();
    end
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    bus.start = 0; bus.pause = 0; bus.abort = 0; bus.auto_reload = 0;
    cyc();

    // load 5, no reload: 5,4,3,2,1,0 with tc on the 0
    do_start(5);
    chk("l5_first", 32'(bus.count), 5);
    for (int k = 4; k >= 0; k--) begin
      cyc();
      chk("l5_seq", 32'(bus.count), k);
      chk("l5_tc", 32'(bus.tc_pulse), (k == 0) ? 1 : 0);
    end
    cyc(); cyc();
    chk("l5_done_hold", 32'(bus.done), 1);
    chk("l5_busy_low", 32'(bus.busy), 0);

    // reset mid-run at count 6
    do_start(9);
    cyc(); cyc(); cyc();
    chk("pre_rst6", 32'(bus.count), 6);
    rst = 1'b1; bus.start = 1'b1; bus.load_val = W'($urandom);
    cyc();
    rst = 1'b0; bus.start = 1'b0;
    chk("rst6_count", 32'(bus.count), 0);
    chk("rst6_busy", 32'(bus.busy), 0);

    // auto-reload period 3
    bus.auto_reload = 1'b1;
    do_start(3);
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("ar_tc", 32'(bus.tc_pulse), (k % 3 == 2) ? 1 : 0);
      chk("ar_seq", 32'(bus.count), 3 - ((k + 1) % 3));
    end
    bus.auto_reload = 1'b0;
    cyc(); cyc(); cyc();
    chk("ar_end_count", 32'(bus.count), 0);
    chk("ar_end_done", 32'(bus.done), 1);

    // pause at 4 and at 1
    do_start(6);
    cyc(); cyc();
    bus.pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("pause4_hold", 32'(bus.count), 4);
    end
    bus.pause = 1'b0;
    cyc(); cyc(); cyc();
    chk("pre_pause1", 32'(bus.count), 1);
    bus.pause = 1'b1;
    cyc(); cyc();
    chk("pause1_no_tc", 32'(bus.tc_pulse), 0);
    bus.pause = 1'b0;
    cyc();
    chk("pause1_tc", 32'(bus.tc_pulse), 1);

    // abort at count 7 of a 200 load, then abort+start from IDLE
    do_start(200);
    for (int k = 0; k < 193; k++) cyc();
    chk("pre_abort", 32'(bus.count), 7);
    bus.abort = 1'b1;
    cyc();
    chk("abort_count", 32'(bus.count), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    bus.load_val = W'(5); bus.start = 1'b1;
    cyc();
    bus.abort = 1'b0; bus.start = 1'b0;
    chk("abort_start_idle", 32'(bus.busy), 0);

    // zero load goes straight to DONE
    do_start(0);
    chk("zero_done", 32'(bus.done), 1);
    chk("zero_tc", 32'(bus.tc_pulse), 1);

    // start during RUN is ignored
    do_start(12);
    cyc();
    do_start(9);
    chk("run_start_ign", 32'(bus.count), 10);
    for (int k = 0; k < 10; k++) cyc();
    chk("run_start_done", 32'(bus.done), 1);

    // full-scale load from DONE
    do_start(255);
    chk("l255_count", 32'(bus.count), 255);
    chk("l255_busy", 32'(bus.busy), 1);
    for (int k = 0; k < 254; k++) cyc();
    chk("l255_pre_tc", 32'(bus.tc_pulse), 0);
    cyc();
    chk("l255_tc", 32'(bus.tc_pulse), 1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst             = ($urandom_range(0, 199) == 0);
      bus.abort       = ($urandom_range(0, 31) == 0);
      bus.start       = ($urandom_range(0, 7) == 0);
      bus.pause       = ($urandom_range(0, 3) == 0);
      bus.auto_reload = 1'($urandom);
      bus.load_val    = ($urandom_range(0, 15) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
